// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_dump_reader
//  Purpose  : Debug/trace read-out engine. On a start request it walks a
//             contiguous range of architectural registers through one
//             combinational regfile read port. Each value is streamed out,
//             tagged with its register index, over a valid/ready interface.
//  Ports    : clk, rst (async, active-low)
//             start, first_reg, last_reg     - dump request and range
//             rd_addr / rd_data              - regfile read port
//             out_valid/out_ready/out_data/out_index - output stream
//             busy                           - any state other than IDLE
//             done                           - one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_reader #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [4:0]   first_reg,
    input  logic [4:0]   last_reg,
    output logic [4:0]   rd_addr,
    input  logic [N-1:0] rd_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [4:0]   out_index,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [4:0]     r_ptr;
    logic [4:0]     w_ptr_nxt;
    logic [4:0]     r_end;
    logic [4:0]     w_end_nxt;
    logic           r_out_valid;
    logic           w_out_valid_nxt;
    logic [N-1:0]   r_out_data;
    logic [N-1:0]   w_out_data_nxt;
    logic [4:0]     r_out_index;
    logic [4:0]     w_out_index_nxt;
    logic           r_done;
    logic           w_done_nxt;
    logic           w_slot_free;

    // The single output register can take a new beat when it is empty or
    // when its current beat leaves this cycle; this gives full throughput
    // without a skid buffer.
    assign w_slot_free = ~r_out_valid | out_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_end_nxt       = r_end;
        w_out_data_nxt  = r_out_data;
        w_out_index_nxt = r_out_index;
        w_done_nxt      = 1'b0;
        // An accepted beat empties the register unless refilled below.
        w_out_valid_nxt = r_out_valid & ~out_ready;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_ptr_nxt   = first_reg;
                    w_end_nxt   = last_reg;
                    // An inverted range produces no beats, only a done pulse.
                    w_state_nxt = (first_reg > last_reg) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (w_slot_free) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_data_nxt  = rd_data;
                    w_out_index_nxt = r_ptr;
                    // Exiting at ptr == end keeps the 5-bit pointer from wrapping.
                    if (r_ptr == r_end) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_ptr_nxt = r_ptr + 5'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (w_slot_free) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 5'd0;
            r_end       <= 5'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= 5'd0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_end       <= w_end_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_index <= w_out_index_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign rd_addr   = r_ptr;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_index = r_out_index;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_dump_reader
//  Purpose  : Self-checking bench for regfile_dump_reader. Holds a small
//             behavioural regfile and builds the expected beat list of each
//             dump from the register range and a regfile snapshot.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_reader;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [4:0]   first_reg;
    logic [4:0]   last_reg;
    logic [4:0]   rd_addr;
    logic [N-1:0] rd_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [4:0]   out_index;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    regfile_dump_reader #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .busy      (busy),
        .done      (done)
    );

    // Behavioural regfile: edge-written, combinational read, x0 reads as 0.
    logic [N-1:0] regs [32];
    logic         we;
    logic [4:0]   wa;
    logic [N-1:0] wd;

    always @(posedge clk) begin
        if (we) regs[wa] <= wd;
    end

    assign rd_data = (rd_addr == 5'd0) ? '0 : regs[rd_addr];

    int checks   = 0;
    int failures = 0;

    // Per-dump options: ready pattern, mid-dump start injection, write injection.
    int           opt_mode;
    int           opt_inj;
    int           opt_wr;
    logic [4:0]   opt_wa;
    logic [N-1:0] opt_wd;
    int           pat [7] = '{1, 0, 0, 1, 0, 1, 1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [N-1:0] d);
        we = 1'b1;
        wa = a;
        wd = d;
        tick();
        we = 1'b0;
    endtask

    // Starts a dump and runs until done (bounded). Returns in the done cycle.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l);
        logic [36:0] expq [$];
        logic [36:0] got  [$];
        logic [36:0] hold;
        logic        hold_v;
        int          n, c, stalls, first_valid, done_cyc, exp_done;

        for (int i = int'(f); i <= int'(l); i++) begin
            expq.push_back({5'(i), (i == 0) ? {N{1'b0}} : regs[5'(i)]});
        end
        n = expq.size();

        first_reg = f;
        last_reg  = l;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_t1", 64'(busy), 64'(1));
        chk("rd_addr_t1", 64'(rd_addr), 64'(f));
        chk("done_t1", 64'(done), 64'(0));

        c = 1; stalls = 0; first_valid = -1; done_cyc = -1;
        hold_v = 1'b0; hold = '0;
        while (c < 200 && done_cyc < 0) begin
            case (opt_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = (c >= 2 && c - 2 < 7) ? (pat[c-2] != 0) : 1'b1;
            endcase
            start = (c == opt_inj);
            if (c == opt_inj) begin
                first_reg = 5'd0;
                last_reg  = 5'd1;
            end
            we = (c == opt_wr);
            wa = opt_wa;
            wd = opt_wd;
            #1;
            if (out_valid && first_valid < 0) first_valid = c;
            if (hold_v) chk("stall_stable", 64'({out_index, out_data}), 64'(hold));
            if (out_valid && out_ready) got.push_back({out_index, out_data});
            hold_v = out_valid && !out_ready;
            hold   = {out_index, out_data};
            if (hold_v) stalls++;
            tick();
            c++;
            start = 1'b0;
            we    = 1'b0;
            if (done) done_cyc = c;
        end

        exp_done = (n == 0) ? 2 : n + 2 + stalls;
        chk("done_cycle", 64'(done_cyc), 64'(exp_done));
        chk("beat_count", 64'(got.size()), 64'(n));
        for (int k = 0; k < n && k < got.size(); k++) begin
            chk("beat", 64'(got[k]), 64'(expq[k]));
        end
        chk("first_valid_cycle", 64'(first_valid), 64'((n == 0) ? -1 : 2));
        chk("busy_in_done", 64'(busy), 64'(0));
        chk("valid_in_done", 64'(out_valid), 64'(0));
    endtask

    // One cycle after a done: pulse must be over and the block idle.
    task automatic idle_check();
        tick();
        chk("done_single", 64'(done), 64'(0));
        chk("busy_idle", 64'(busy), 64'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        first_reg = '0; last_reg = '0;
        we = 1'b0; wa = '0; wd = '0;
        opt_mode = 0; opt_inj = -1; opt_wr = -1; opt_wa = '0; opt_wd = '0;

        #2 rst = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_index", 64'(out_index), 64'(0));
        chk("rst_rd_addr", 64'(rd_addr), 64'(0));
        tick();
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 32; i++) wr(5'(i), 32'h1000_0000 + 32'(i));

        // Full dump, ready held high
        run_dump(5'd0, 5'd31);
        idle_check();

        // Back-pressure pattern
        opt_mode = 2;
        run_dump(5'd5, 5'd8);
        idle_check();
        opt_mode = 0;

        // Single and empty ranges
        run_dump(5'd12, 5'd12);
        idle_check();
        run_dump(5'd20, 5'd3);
        idle_check();

        // Start while busy is ignored
        opt_inj = 4;
        run_dump(5'd1, 5'd10);
        opt_inj = -1;
        idle_check();
        run_dump(5'd0, 5'd1);
        idle_check();

        // Back-to-back: second start sampled in the done cycle
        run_dump(5'd4, 5'd6);
        run_dump(5'd7, 5'd9);
        idle_check();

        // Reset mid-dump after three accepted beats
        first_reg = 5'd1; last_reg = 5'd31; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2 rst = 1'b0;
        #1;
        chk("abort_valid", 64'(out_valid), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_done", 64'(done), 64'(0));
        end
        run_dump(5'd2, 5'd3);
        idle_check();

        // Write collision at the capture edge of index 3
        opt_wr = 3; opt_wa = 5'd3; opt_wd = 32'hDEAD_BEEF;
        run_dump(5'd1, 5'd4);
        opt_wr = -1;
        idle_check();
        run_dump(5'd3, 5'd3);
        idle_check();

        // Randomised ranges, data and ready
        for (int it = 0; it < 8; it++) begin
            for (int j = 0; j < 3; j++) wr(5'($urandom_range(0, 31)), $urandom);
            opt_mode = 1;
            run_dump(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            idle_check();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
